// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for counters and FIFO pointer synchronisers.
// Contents: gray_word_t (widest supported word), cnt_op_e (counter operation),
// bin2gray / gray2bin / max_val functions. Widths up to GRAY_MAX_W bits;
// narrower values are zero-extended into a gray_word_t before the call.
package gray_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    // Operation selected by the counter for the current cycle
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } cnt_op_e;

    // Binary to Gray; zero upper bits make it valid for any width
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // All-ones value of a w-bit counter, 1 <= w <= GRAY_MAX_W
    function automatic gray_word_t max_val(input int unsigned w);
        gray_word_t m;
        m = '1;
        return m >> (GRAY_MAX_W - w);
    endfunction

endpackage

// File: rtl/gray_counter_gray2bin_dec.sv
// Combinational WIDTH-bit Gray-to-binary decoder (load path, pointer synchronisers).
// Ports: i_gray - Gray-coded input; o_bin - binary equivalent.
module gray2bin_dec
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    assign o_bin = WIDTH'(gray2bin(gray_word_t'(i_gray)));

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with registered binary and Gray views, wrap or
// saturate at the bounds, and a registered terminal-count pulse.
// Optional feature macro: GRAY_CNT_LOAD_EN adds load/load_gray and the decoder.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   en, up       - count enable, direction (1 = increment)
//   load         - load request (GRAY_CNT_LOAD_EN only)
//   load_gray    - Gray value to load (GRAY_CNT_LOAD_EN only)
//   bin, grey    - registered binary count and its Gray code
//   tc           - registered pulse on each boundary wrap / blocked step
//   at_max/at_min- combinational bound flags from bin
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter bit          WRAP    = 1'b1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
`ifdef GRAY_CNT_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
`endif
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] grey,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(max_val(WIDTH));
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(gray_word_t'(RST_BIN)));

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_grey;
    logic             r_tc;

    cnt_op_e          w_op;
    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_grey;
    logic             w_next_tc;
    logic             w_at_max;
    logic             w_at_min;

`ifdef GRAY_CNT_LOAD_EN
    logic [WIDTH-1:0] w_load_bin;

    gray2bin_dec #(
        .WIDTH (WIDTH)
    ) u_dec (
        .i_gray (load_gray),
        .o_bin  (w_load_bin)
    );
`endif

    assign w_at_max = (r_bin == MAX_VAL);
    assign w_at_min = (r_bin == '0);

    // Operation decode; the later load assignment gives load priority over en
    always_comb begin
        w_op = OP_HOLD;
        if (en) begin
            w_op = up ? OP_INC : OP_DEC;
        end
`ifdef GRAY_CNT_LOAD_EN
        if (load) begin
            w_op = OP_LOAD;
        end
`endif
    end

    // Next count; bound decision comes from the current value, not a carry
    always_comb begin
        w_next_bin = r_bin;
        w_next_tc  = 1'b0;
        case (w_op)
            OP_INC: begin
                if (w_at_max) begin
                    w_next_tc = 1'b1;
                    if (WRAP) w_next_bin = '0;
                end else begin
                    w_next_bin = r_bin + WIDTH'(1);
                end
            end
            OP_DEC: begin
                if (w_at_min) begin
                    w_next_tc = 1'b1;
                    if (WRAP) w_next_bin = MAX_VAL;
                end else begin
                    w_next_bin = r_bin - WIDTH'(1);
                end
            end
            default: ;
        endcase
        // Gray register is fed from the next count so its output never glitches
        w_next_grey = WIDTH'(bin2gray(gray_word_t'(w_next_bin)));
`ifdef GRAY_CNT_LOAD_EN
        if (w_op == OP_LOAD) begin
            w_next_bin  = w_load_bin;
            w_next_grey = load_gray;
        end
`endif
    end

    // Count, Gray and terminal-count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= RST_BIN;
            r_grey <= RST_GRAY;
            r_tc   <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_grey <= w_next_grey;
            r_tc   <= w_next_tc;
        end
    end

    assign bin    = r_bin;
    assign grey   = r_grey;
    assign tc     = r_tc;
    assign at_max = w_at_max;
    assign at_min = w_at_min;

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised synchronous Gray-code counter, the successor to the team's combinational 4-bit binary-to-Gray converter. Holds a binary count and emits registered binary and Gray-code views of it, with count up/down, enable, wrap or saturate at the bounds, a terminal-count pulse and an optional Gray-value load. It is the pointer and sequence source for clock-domain-crossing FIFOs and for rotary and position encoders elsewhere in the design.

## Interface
- WIDTH, 4: counter width in bits, ≥2.
- WRAP, 1: 1 = wrap at the bounds (modulo 2^WIDTH); 0 = saturate at the bounds.
- RST_VAL, 0: binary reset value, 0 ≤ RST_VAL ≤ 2^WIDTH−1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement. Sampled only when en=1.
- load  input  1  load request. Present only with GRAY_CNT_LOAD_EN.
- load_gray  input  WIDTH  Gray-coded value to load. Present only with GRAY_CNT_LOAD_EN.
- bin  output  WIDTH  registered binary count.
- grey  output  WIDTH  registered Gray code of bin, grey = bin ^ (bin >> 1).
- tc  output  1  registered terminal-count pulse.
- at_max  output  1  combinational, bin == 2^WIDTH−1.
- at_min  output  1  combinational, bin == 0.

## Operation
- Priority is rst, then load, then en. Hold applies when none of these is active.
- Reset:
  - bin ← RST_VAL.
  - grey ← Gray(RST_VAL).
  - tc ← 0.
- Load (macro enabled):
  - bin ← Gray-to-binary(load_gray).
  - grey ← load_gray.
  - tc ← 0.
  - Overrides en in the same cycle.
- Count, en=1, up=1:
  - Below the maximum: bin+1.
  - At 2^WIDTH−1 with WRAP=1: bin ← 0 and tc ← 1.
  - At 2^WIDTH−1 with WRAP=0: bin holds and tc ← 1.
- Count, en=1, up=0:
  - Above zero: bin−1.
  - At 0 with WRAP=1: bin ← 2^WIDTH−1 and tc ← 1.
  - At 0 with WRAP=0: bin holds and tc ← 1.
- tc is otherwise 0. It is a one-cycle pulse per boundary event. With WRAP=0 and en held at the bound, tc stays high for every blocked attempt.
- Hold (en=0, no load): bin and grey are unchanged and tc ← 0.
- Arithmetic is WIDTH-bit unsigned. The wrap/saturate decision comes from the current bin, never from a carry-out beyond WIDTH bits.
- grey is a flop loaded from Gray(next_bin). It is never decoded combinationally from the bin register, so it is glitch-free for CDC sampling.
- Every count step changes exactly one grey bit, including the wrap step. Load and reset may change any number of bits.
- A direction change between consecutive cycles takes effect immediately, with no dead cycle.

## Timing
- Latency: one cycle from sampled en/up/load/rst to bin, grey and tc.
- at_max and at_min follow bin combinationally in the same cycle.
- rst asserted mid-count takes effect on the next edge and discards any concurrent en or load.
- No handshake; en may stay high indefinitely.
- No state machine beyond the count register and the tc flop.

## Configuration
- GRAY_CNT_LOAD_EN:
  - Defined: the load and load_gray ports and the load path, including the Gray-to-binary decoder, are compiled in.
  - Undefined: the ports are absent, the priority reduces to rst, then en, and the decoder is not instantiated.

## Structure
- Shared package gray_pkg holds:
  - function bin2gray(WIDTH-generic);
  - function gray2bin(prefix XOR from the MSB down);
  - localparam-style helpers for the max value.
- Sub-module gray2bin_dec: combinational WIDTH-parametrised Gray-to-binary decoder used on the load path. It is reused by the FIFO pointer synchronisers.

## Test plan
- Reset, WIDTH=4, RST_VAL=5: rst high one cycle → bin=0101, grey=0111, tc=0; en ignored during rst.
- Up-count with WRAP=1: en=1, up=1 for 17 cycles from 0 → bin runs 0..15 then 0, grey 0000,0001,0011,…,1000,0000, tc=1 exactly the cycle after 15→0, single-bit grey change on every step.
- Down-count wrap: bin=0, up=0, en=1 → bin=1111, grey=1000, tc=1, then bin=1110, tc=0.
- Saturate with WRAP=0: count up to 15, hold en=1 for 3 more cycles → bin stays 15, at_max=1, tc=1 all 3 cycles; switch up=0 → bin=14, tc=0.
- Load (macro on): load=1, load_gray=1101, en=1 same cycle → bin=1001, grey=1101, tc=0; next cycle with en=1, up=1 → bin=1010, grey=1111.
- Hold and mid-operation reset: en=0 for 4 cycles → outputs unchanged, tc=0; rst asserted during an active count → next edge bin=RST_VAL.
